banco_registros_param: RTL and testbench

Parametrised next-generation register bank. Holds NUM_REGS registers of DATA_W bits each, with full-width or single-byte-lane access. Supports a two-cycle atomic exchange of two registers behind a valid/ready request handshake. Uses separate write and read data buses, so no bidirectional pin is needed, and read data is registered with a valid strobe so the bench scoreboard can sample it.

---
 rtl/banco_registros_param_if.sv | 50 +++++
 rtl/banco_registros_param.sv | 224 ++++++++++++++++++++++
 tb/tb_banco_registros_param.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/banco_registros_param_if.sv
// ---------------------------------------------------------------------------
// banco_registros_param_if
// Request/response bundle for the banco_registros_param register bank.
//
// Handshake: a request transfers on a rising clk edge where req_valid=1 and
// req_ready=1. While req_ready=0 the master must hold req_valid and every
// request field stable. Responses (rdata) are qualified by the one-cycle
// rdata_valid strobe and are never back-pressured.
//
// Signals:
//   req_valid   master->slave  request present
//   req_ready   slave->master  bank accepts a request this cycle
//   op          master->slave  00 READ, 01 WRITE, 10 XCHG, 11 NOP
//   reg_a       master->slave  primary register index
//   reg_b       master->slave  XCHG partner index
//   size        master->slave  1 = full word, 0 = single byte lane
//   byte_sel    master->slave  byte lane used when size=0
//   wdata       master->slave  write data (byte writes use wdata[7:0])
//   rdata       slave->master  registered READ / XCHG result
//   rdata_valid slave->master  one-cycle strobe qualifying rdata
// ---------------------------------------------------------------------------
interface banco_registros_param_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam int LANES  = DATA_W / 8;
   localparam int BSEL_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic              req_valid;
   logic              req_ready;
   logic [1:0]        op;
   logic [ADDR_W-1:0] reg_a;
   logic [ADDR_W-1:0] reg_b;
   logic              size;
   logic [BSEL_W-1:0] byte_sel;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;

   modport master (
      output req_valid, op, reg_a, reg_b, size, byte_sel, wdata,
      input  req_ready, rdata, rdata_valid
   );

   modport slave (
      input  req_valid, op, reg_a, reg_b, size, byte_sel, wdata,
      output req_ready, rdata, rdata_valid
   );
endinterface

// File: rtl/banco_registros_param.sv
// ---------------------------------------------------------------------------
// banco_registros_param
// Parametrised register bank: NUM_REGS registers of DATA_W bits with
// full-word or single-byte-lane READ/WRITE and a two-cycle atomic exchange
// (XCHG) of two registers. Read data is registered and qualified by a
// one-cycle rdata_valid strobe.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (clears all registers)
//   bus        banco_registros_param_if.slave request/response bundle
//   state_dbg  current FSM state (0 = IDLE, 1 = SWAP)
//
// Optional feature (compile-time macro BANCO_ZERO_REG_EN):
//   defined   -> register 0 is hardwired to zero: writes to it are dropped,
//                reads return 0, and an XCHG with it writes 0 into the
//                partner.
//   undefined -> register 0 is an ordinary register.
//
// Out-of-range register indices (NUM_REGS not a power of two) and byte
// lanes >= LANES behave alike: writes are dropped and reads return 0.
// ---------------------------------------------------------------------------
module banco_registros_param #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   banco_registros_param_if.slave  bus,
   output logic                    state_dbg
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam int LANES  = DATA_W / 8;
   localparam int BSEL_W = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_XCHG  = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SWAP = 1'b1
   } state_e;

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------

   // A register index is "live" when it addresses real storage. With the
   // zero-register option, index 0 is not live: it reads as 0 and ignores
   // writes, which also gives the XCHG-with-zero behaviour for free.
   function automatic logic reg_live(input logic [ADDR_W-1:0] idx);
      logic ok;
      ok = (int'(idx) < NUM_REGS);
`ifdef BANCO_ZERO_REG_EN
      if (idx == '0) begin
         ok = 1'b0;
      end
`endif
      return ok;
   endfunction

   function automatic logic lane_ok(input logic [BSEL_W-1:0] sel);
      return (int'(sel) < LANES);
   endfunction

   // Byte lane 'sel' of 'word', zero-extended; 0 for a nonexistent lane.
   function automatic logic [DATA_W-1:0] get_lane(input logic [DATA_W-1:0] word,
                                                  input logic [BSEL_W-1:0] sel);
      logic [DATA_W-1:0] shifted;
      shifted = word >> (8 * int'(sel));
      if (!lane_ok(sel)) begin
         return '0;
      end
      return DATA_W'(shifted[7:0]);
   endfunction

   // 'word' with lane 'sel' replaced by 'b'; unchanged for a nonexistent lane.
   function automatic logic [DATA_W-1:0] put_lane(input logic [DATA_W-1:0] word,
                                                  input logic [BSEL_W-1:0] sel,
                                                  input logic [7:0]        b);
      logic [DATA_W-1:0] mask;
      logic [DATA_W-1:0] ins;
      mask = DATA_W'(8'hFF) << (8 * int'(sel));
      ins  = DATA_W'(b) << (8 * int'(sel));
      if (!lane_ok(sel)) begin
         return word;
      end
      return (word & ~mask) | (ins & mask);
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
   logic [DATA_W-1:0] tmp_b_q, tmp_b_d;
   logic [ADDR_W-1:0] xa_q, xa_d;
   logic [ADDR_W-1:0] xb_q, xb_d;
   logic              xsize_q, xsize_d;
   logic [BSEL_W-1:0] xsel_q, xsel_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rdata_valid_q, rdata_valid_d;

   // Combinational read values (already masked for dead indices)
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] lane_a;
   logic [DATA_W-1:0] lane_b;

   assign bus.req_ready   = (state_q == ST_IDLE);
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;
   assign state_dbg       = (state_q == ST_SWAP);

   // ---------------------------------------------------------------------
   // Next-state / datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      regs_d        = regs_q;
      tmp_a_d       = tmp_a_q;
      tmp_b_d       = tmp_b_q;
      xa_d          = xa_q;
      xb_d          = xb_q;
      xsize_d       = xsize_q;
      xsel_d        = xsel_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      rd_a          = reg_live(bus.reg_a) ? regs_q[bus.reg_a] : '0;
      rd_b          = reg_live(bus.reg_b) ? regs_q[bus.reg_b] : '0;
      lane_a        = get_lane(tmp_a_q, xsel_q);
      lane_b        = get_lane(tmp_b_q, xsel_q);

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               case (bus.op)
                  OP_READ: begin
                     rdata_d       = bus.size ? rd_a : get_lane(rd_a, bus.byte_sel);
                     rdata_valid_d = 1'b1;
                  end
                  OP_WRITE: begin
                     if (reg_live(bus.reg_a)) begin
                        regs_d[bus.reg_a] = bus.size ? bus.wdata
                                          : put_lane(regs_q[bus.reg_a], bus.byte_sel,
                                                     bus.wdata[7:0]);
                     end
                  end
                  OP_XCHG: begin
                     // Snapshot both operands now so the SWAP edge writes
                     // each register with the other's pre-exchange value.
                     tmp_a_d = rd_a;
                     tmp_b_d = rd_b;
                     xa_d    = bus.reg_a;
                     xb_d    = bus.reg_b;
                     xsize_d = bus.size;
                     xsel_d  = bus.byte_sel;
                     state_d = ST_SWAP;
                  end
                  default: begin
                     // NOP: accepted, nothing changes
                  end
               endcase
            end
         end

         ST_SWAP: begin
            // When xa == xb the second write re-applies the original value,
            // so the register ends up unchanged.
            if (reg_live(xa_q)) begin
               regs_d[xa_q] = xsize_q ? tmp_b_q
                            : put_lane(regs_q[xa_q], xsel_q, lane_b[7:0]);
            end
            if (reg_live(xb_q)) begin
               regs_d[xb_q] = xsize_q ? tmp_a_q
                            : put_lane(regs_q[xb_q], xsel_q, lane_a[7:0]);
            end
            rdata_d       = xsize_q ? tmp_a_q : lane_a;
            rdata_valid_d = 1'b1;
            state_d       = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers (reset overrides an in-flight exchange)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         tmp_a_q       <= '0;
         tmp_b_q       <= '0;
         xa_q          <= '0;
         xb_q          <= '0;
         xsize_q       <= 1'b0;
         xsel_q        <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         tmp_a_q       <= tmp_a_d;
         tmp_b_q       <= tmp_b_d;
         xa_q          <= xa_d;
         xb_q          <= xb_d;
         xsize_q       <= xsize_d;
         xsel_q        <= xsel_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end
endmodule

// File: tb/tb_banco_registros_param.sv
// ---------------------------------------------------------------------------
// tb_banco_registros_param
// Self-checking bench for banco_registros_param (DATA_W=16, NUM_REGS=8).
// Requests are driven on the falling edge; every READ/XCHG pushes its
// expected rdata and the cycle it must appear into queues, and a falling-
// edge monitor pops and compares each rdata_valid pulse.
// ---------------------------------------------------------------------------
module tb_banco_registros_param;
   localparam int W = 16;
   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_XCHG  = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic state_dbg;
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   banco_registros_param_if #(.DATA_W(W), .NUM_REGS(8)) bus ();

   banco_registros_param #(.DATA_W(W), .NUM_REGS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           due_q[$];
   logic [W-1:0] mdl [8];

   always @(negedge clk) begin
      if (bus.rdata_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rdata_valid: rdata=%h at cycle %0d, nothing expected",
                     bus.rdata, cyc);
         end else begin
            logic [W-1:0] e;
            int           d;
            e = exp_q.pop_front();
            d = due_q.pop_front();
            if (bus.rdata !== e || cyc != d) begin
               n_fail++;
               $display("FAIL rdata: got %h at cycle %0d, expected %h at cycle %0d",
                        bus.rdata, cyc, e, d);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic sz, input logic sel, input logic [W-1:0] wd,
                       input bit chk, input logic [W-1:0] exp, output int waited);
      bus.req_valid = 1'b1;
      bus.op        = op;
      bus.reg_a     = a;
      bus.reg_b     = b;
      bus.size      = sz;
      bus.byte_sel  = sel;
      bus.wdata     = wd;
      waited        = 0;
      while (bus.req_ready !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (waited >= 8) begin
         n_fail++;
         $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, waited);
      end
      if (chk) begin
         exp_q.push_back(exp);
         due_q.push_back(cyc + ((op == OP_XCHG) ? 2 : 1));
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.op        = OP_NOP;
   endtask

   task automatic rd(input logic [2:0] a, input logic sz, input logic sel, input logic [W-1:0] exp);
      int w;
      send(OP_READ, a, 3'd0, sz, sel, '0, 1'b1, exp, w);
   endtask

   task automatic wr(input logic [2:0] a, input logic sz, input logic sel, input logic [W-1:0] wd);
      int w;
      send(OP_WRITE, a, 3'd0, sz, sel, wd, 1'b0, '0, w);
   endtask

   task automatic xchg(input logic [2:0] a, input logic [2:0] b, input logic sz,
                       input logic sel, input logic [W-1:0] exp);
      int w;
      send(OP_XCHG, a, b, sz, sel, '0, 1'b1, exp, w);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus.req_valid = 1'b0;
      bus.op        = OP_NOP;
      bus.reg_a     = '0;
      bus.reg_b     = '0;
      bus.size      = 1'b1;
      bus.byte_sel  = '0;
      bus.wdata     = '0;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.rdata !== 16'h0000 || bus.rdata_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdata=%h valid=%b, required 0000/0", bus.rdata, bus.rdata_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b1 || state_dbg !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: req_ready=%b state=%b, required 1/0", bus.req_ready, state_dbg);
      end
      for (int i = 0; i < 8; i++) rd(3'(i), 1'b1, 1'b0, 16'h0000);
   endtask

   task automatic test_write_read();
      wr(3'd3, 1'b1, 1'b0, 16'hA5C3);
      rd(3'd3, 1'b1, 1'b0, 16'hA5C3);
   endtask

   task automatic test_byte_lanes();
      wr(3'd3, 1'b0, 1'b1, 16'h007E);
      rd(3'd3, 1'b1, 1'b0, 16'h7EC3);
      rd(3'd3, 1'b0, 1'b0, 16'h00C3);
      rd(3'd3, 1'b0, 1'b1, 16'h007E);
   endtask

   task automatic test_xchg();
      int w;
      wr(3'd2, 1'b1, 1'b0, 16'h1111);
      wr(3'd5, 1'b1, 1'b0, 16'h2222);
      xchg(3'd2, 3'd5, 1'b1, 1'b0, 16'h1111);
      n_checks++;
      if (bus.req_ready !== 1'b0 || state_dbg !== 1'b1) begin
         n_fail++;
         $display("FAIL xchg_swap_state: req_ready=%b state=%b, required 0/1", bus.req_ready, state_dbg);
      end
      // Request held while the bank is busy; must wait exactly one cycle.
      send(OP_READ, 3'd2, 3'd0, 1'b1, 1'b0, '0, 1'b1, 16'h2222, w);
      n_checks++;
      if (w != 1) begin
         n_fail++;
         $display("FAIL xchg_busy_cycles: waited %0d, required 1", w);
      end
      rd(3'd5, 1'b1, 1'b0, 16'h1111);
   endtask

   task automatic test_xchg_lane();
      xchg(3'd2, 3'd5, 1'b0, 1'b0, 16'h0022);
      rd(3'd2, 1'b1, 1'b0, 16'h2211);
      rd(3'd5, 1'b1, 1'b0, 16'h1122);
   endtask

   task automatic test_back_to_back();
      wr(3'd4, 1'b1, 1'b0, 16'h3C5A);
      xchg(3'd4, 3'd4, 1'b1, 1'b0, 16'h3C5A);
      xchg(3'd4, 3'd4, 1'b0, 1'b1, 16'h003C);
      rd(3'd4, 1'b1, 1'b0, 16'h3C5A);
   endtask

   task automatic test_nop();
      int w;
      send(OP_NOP, 3'd4, 3'd0, 1'b1, 1'b0, 16'hFFFF, 1'b0, '0, w);
      repeat (3) @(negedge clk);
      rd(3'd4, 1'b1, 1'b0, 16'h3C5A);
   endtask

   task automatic test_reset_swap();
      int w;
      wr(3'd1, 1'b1, 1'b0, 16'hBEEF);
      wr(3'd6, 1'b1, 1'b0, 16'h0001);
      send(OP_XCHG, 3'd1, 3'd6, 1'b1, 1'b0, '0, 1'b0, '0, w);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.rdata !== 16'h0000 || bus.rdata_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_swap: rdata=%h valid=%b, required 0000/0", bus.rdata, bus.rdata_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      rd(3'd1, 1'b1, 1'b0, 16'h0000);
      rd(3'd6, 1'b1, 1'b0, 16'h0000);
      rd(3'd3, 1'b1, 1'b0, 16'h0000);
   endtask

   task automatic test_zero_reg();
`ifdef BANCO_ZERO_REG_EN
      wr(3'd0, 1'b1, 1'b0, 16'hFFFF);
      rd(3'd0, 1'b1, 1'b0, 16'h0000);
      wr(3'd5, 1'b1, 1'b0, 16'h1234);
      xchg(3'd0, 3'd5, 1'b1, 1'b0, 16'h0000);
      rd(3'd5, 1'b1, 1'b0, 16'h0000);
      rd(3'd0, 1'b1, 1'b0, 16'h0000);
`else
      wr(3'd0, 1'b1, 1'b0, 16'hFFFF);
      rd(3'd0, 1'b1, 1'b0, 16'hFFFF);
`endif
   endtask

   task automatic test_random();
      logic [2:0]   a;
      logic [W-1:0] d;
      for (int i = 0; i < 8; i++) begin
         d = W'($urandom_range(0, 16'hFFFF));
         wr(3'(i), 1'b1, 1'b0, d);
         mdl[i] = d;
`ifdef BANCO_ZERO_REG_EN
         if (i == 0) mdl[i] = '0;
`endif
      end
      for (int n = 0; n < 40; n++) begin
         a = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            d = W'($urandom_range(0, 16'hFFFF));
            wr(a, 1'b1, 1'b0, d);
`ifdef BANCO_ZERO_REG_EN
            if (a != 3'd0) mdl[a] = d;
`else
            mdl[a] = d;
`endif
         end else begin
            rd(a, 1'b1, 1'b0, mdl[a]);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_xchg();
      test_xchg_lane();
      test_back_to_back();
      test_nop();
      test_reset_swap();
      test_zero_reg();
      test_random();
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_responses: %0d outstanding, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
